// File: rtl/td4_sequencer.sv
// TD4 4-bit CPU control sequencer: HALT/FETCH/EXEC state machine, program
// counter, instruction register, carry flag and operand/load-enable decode.
module td4_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       run,
    input  logic       step,
    output logic       rom_req,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    output logic [3:0] pc,
    output logic [3:0] imm,
    output logic [1:0] sel,
    input  logic       cout,
    output logic       n_en_a,
    output logic       n_en_b,
    output logic       n_en_out,
    output logic       carry,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DST_A    = 2'd0,
        DST_B    = 2'd1,
        DST_OUT  = 2'd2,
        DST_NONE = 2'd3
    } dst_t;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_IN   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       carry_q, carry_d;
    logic       ss_q, ss_d;

    logic [1:0] dec_sel;
    dst_t       dec_dst;
    logic       dec_valid;
    logic       dec_jmp;
    logic       dec_jnc;

    // Instruction decode from the held IR opcode.
    always_comb begin
        dec_sel   = SEL_ZERO;
        dec_dst   = DST_NONE;
        dec_valid = 1'b1;
        dec_jmp   = 1'b0;
        dec_jnc   = 1'b0;
        case (ir_q[7:4])
            4'b0000: begin dec_sel = SEL_A;    dec_dst = DST_A;   end
            4'b0101: begin dec_sel = SEL_B;    dec_dst = DST_B;   end
            4'b0011: begin dec_sel = SEL_ZERO; dec_dst = DST_A;   end
            4'b0111: begin dec_sel = SEL_ZERO; dec_dst = DST_B;   end
            4'b0001: begin dec_sel = SEL_B;    dec_dst = DST_A;   end
            4'b0100: begin dec_sel = SEL_A;    dec_dst = DST_B;   end
            4'b0010: begin dec_sel = SEL_IN;   dec_dst = DST_A;   end
            4'b0110: begin dec_sel = SEL_IN;   dec_dst = DST_B;   end
            4'b1001: begin dec_sel = SEL_B;    dec_dst = DST_OUT; end
            4'b1011: begin dec_sel = SEL_ZERO; dec_dst = DST_OUT; end
            4'b1111: begin dec_sel = SEL_ZERO; dec_jmp = 1'b1;    end
            4'b1110: begin dec_sel = SEL_ZERO; dec_jnc = 1'b1;    end
            default: dec_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_HALT;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            carry_q <= 1'b0;
            ss_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            ss_q    <= ss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        ss_d    = ss_q;
        case (state_q)
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                end else if (step) begin
                    state_d = S_FETCH;
                    ss_d    = 1'b1;
                end
            end
            S_FETCH: begin
                if (rom_ack) begin
                    ir_d    = rom_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d = pc_q + 4'd1;
                // JNC tests the carry as it stood before this instruction.
                if (dec_jmp || (dec_jnc && !carry_q)) begin
                    pc_d = ir_q[3:0];
                end
                if (dec_valid) begin
                    carry_d = cout;
                end
                state_d = (run && !ss_q) ? S_FETCH : S_HALT;
                ss_d    = 1'b0;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        rom_req  = (state_q == S_FETCH);
        halted   = (state_q == S_HALT);
        imm      = ir_q[3:0];
        sel      = SEL_ZERO;
        n_en_a   = 1'b1;
        n_en_b   = 1'b1;
        n_en_out = 1'b1;
        illegal  = 1'b0;
        if (state_q == S_EXEC) begin
            sel      = dec_sel;
            n_en_a   = (dec_dst != DST_A);
            n_en_b   = (dec_dst != DST_B);
            n_en_out = (dec_dst != DST_OUT);
            illegal  = !dec_valid;
        end
    end

    assign pc    = pc_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: emulates the TD4 datapath and ROM around the
// sequencer and checks it against an instruction-level reference model.
module tb_td4_sequencer;

    logic       clk;
    logic       n_reset;
    logic       run;
    logic       step;
    logic       rom_req;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic [3:0] pc;
    logic [3:0] imm;
    logic [1:0] sel;
    logic       cout;
    logic       n_en_a;
    logic       n_en_b;
    logic       n_en_out;
    logic       carry;
    logic       halted;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    td4_sequencer #(.RESET_PC(4'h0)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .run      (run),
        .step     (step),
        .rom_req  (rom_req),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .pc       (pc),
        .imm      (imm),
        .sel      (sel),
        .cout     (cout),
        .n_en_a   (n_en_a),
        .n_en_b   (n_en_b),
        .n_en_out (n_en_out),
        .carry    (carry),
        .halted   (halted),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: ROM, adder, A/B/OUT registers, acknowledge generator.
    logic [7:0] rom [16];
    logic [3:0] in_port;
    logic [3:0] env_a, env_b, env_o;
    logic [3:0] operand;
    logic [4:0] sum;
    int         ack_delay;
    int         wait_cnt;
    logic       ack_force;

    assign rom_data = rom[pc];
    assign rom_ack  = ack_force || (rom_req && (wait_cnt >= ack_delay));
    assign cout     = sum[4];

    always_comb begin
        case (sel)
            2'd0:    operand = env_a;
            2'd1:    operand = env_b;
            2'd2:    operand = in_port;
            default: operand = 4'd0;
        endcase
        sum = {1'b0, operand} + {1'b0, imm};
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            env_a    <= 4'd0;
            env_b    <= 4'd0;
            env_o    <= 4'd0;
            wait_cnt <= 0;
        end else begin
            if (!n_en_a)   env_a <= sum[3:0];
            if (!n_en_b)   env_b <= sum[3:0];
            if (!n_en_out) env_o <= sum[3:0];
            if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
            else                     wait_cnt <= 0;
        end
    end

    // Reference model: phase 0=halt, 1=fetch, 2=exec; data effects follow the ISA.
    int sel_tab [16];
    int dst_tab [16];

    logic [1:0] m_phase, m_phase_n;
    logic [3:0] m_pc, m_pc_n, m_a, m_a_n, m_b, m_b_n, m_o, m_o_n;
    logic [7:0] m_ir, m_ir_n;
    logic       m_c, m_c_n, m_ss, m_ss_n;
    logic [4:0] im5, r;

    always_comb begin
        m_phase_n = m_phase;
        m_pc_n    = m_pc;
        m_a_n     = m_a;
        m_b_n     = m_b;
        m_o_n     = m_o;
        m_ir_n    = m_ir;
        m_c_n     = m_c;
        m_ss_n    = m_ss;
        im5       = {1'b0, m_ir[3:0]};
        r         = 5'd0;
        case (m_phase)
            2'd0: begin
                if (run) m_phase_n = 2'd1;
                else if (step) begin m_phase_n = 2'd1; m_ss_n = 1'b1; end
            end
            2'd1: begin
                if (rom_ack) begin m_ir_n = rom[m_pc]; m_phase_n = 2'd2; end
            end
            default: begin
                m_pc_n = m_pc + 4'd1;
                case (m_ir[7:4])
                    4'h0: begin r = {1'b0, m_a} + im5;     m_a_n = r[3:0]; m_c_n = r[4]; end
                    4'h5: begin r = {1'b0, m_b} + im5;     m_b_n = r[3:0]; m_c_n = r[4]; end
                    4'h3: begin r = im5;                   m_a_n = r[3:0]; m_c_n = r[4]; end
                    4'h7: begin r = im5;                   m_b_n = r[3:0]; m_c_n = r[4]; end
                    4'h1: begin r = {1'b0, m_b} + im5;     m_a_n = r[3:0]; m_c_n = r[4]; end
                    4'h4: begin r = {1'b0, m_a} + im5;     m_b_n = r[3:0]; m_c_n = r[4]; end
                    4'h2: begin r = {1'b0, in_port} + im5; m_a_n = r[3:0]; m_c_n = r[4]; end
                    4'h6: begin r = {1'b0, in_port} + im5; m_b_n = r[3:0]; m_c_n = r[4]; end
                    4'h9: begin r = {1'b0, m_b} + im5;     m_o_n = r[3:0]; m_c_n = r[4]; end
                    4'hB: begin r = im5;                   m_o_n = r[3:0]; m_c_n = r[4]; end
                    4'hF: begin m_pc_n = m_ir[3:0]; m_c_n = 1'b0; end
                    4'hE: begin
                        if (!m_c) m_pc_n = m_ir[3:0];
                        m_c_n = 1'b0;
                    end
                    default: ;
                endcase
                m_phase_n = (run && !m_ss) ? 2'd1 : 2'd0;
                m_ss_n    = 1'b0;
            end
        endcase
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_phase <= 2'd0;
            m_pc    <= 4'h0;
            m_a     <= 4'd0;
            m_b     <= 4'd0;
            m_o     <= 4'd0;
            m_ir    <= 8'h00;
            m_c     <= 1'b0;
            m_ss    <= 1'b0;
        end else begin
            m_phase <= m_phase_n;
            m_pc    <= m_pc_n;
            m_a     <= m_a_n;
            m_b     <= m_b_n;
            m_o     <= m_o_n;
            m_ir    <= m_ir_n;
            m_c     <= m_c_n;
            m_ss    <= m_ss_n;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic ex;
        int   op;
        ex = (m_phase == 2'd2);
        op = int'(m_ir[7:4]);
        chk("halted",   halted,   m_phase == 2'd0);
        chk("rom_req",  rom_req,  m_phase == 2'd1);
        chk("pc",       pc,       m_pc);
        chk("imm",      imm,      m_ir[3:0]);
        chk("carry",    carry,    m_c);
        chk("n_en_a",   n_en_a,   !(ex && dst_tab[op] == 0));
        chk("n_en_b",   n_en_b,   !(ex && dst_tab[op] == 1));
        chk("n_en_out", n_en_out, !(ex && dst_tab[op] == 2));
        chk("illegal",  illegal,  ex && dst_tab[op] == 4);
        if (!(ex && sel_tab[op] < 0))
            chk("sel", sel, ex ? 8'(sel_tab[op]) : 8'd3);
        chk("reg_a",    env_a,    m_a);
        chk("reg_b",    env_b,    m_b);
        chk("reg_out",  env_o,    m_o);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic step_once(output int reqs, output int ills);
        reqs = 0;
        ills = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (halted) break;
            if (rom_req) reqs++;
            if (illegal) ills++;
            tick();
        end
        chk("step_done", halted, 1'b1);
        $display("step: ir=%02h pc=%0h carry=%0b a=%0h b=%0h out=%0h req_cycles=%0d illegal_cycles=%0d",
                 m_ir, pc, carry, env_a, env_b, env_o, reqs, ills);
    endtask

    logic [3:0] p1_pc  [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    logic       p1_c   [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] p1_a   [12] = '{4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h6, 4'h6};
    logic [3:0] p2_pc  [5]  = '{4'h1, 4'h2, 4'h3, 4'hF, 4'h0};
    logic       p2_c   [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] p2_ill [5]  = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

    initial begin
        int reqs, ills;
        for (int i = 0; i < 16; i++) begin
            sel_tab[i] = -1;
            dst_tab[i] = 4;
            rom[i]     = 8'h00;
        end
        sel_tab[0]  = 0; dst_tab[0]  = 0;
        sel_tab[5]  = 1; dst_tab[5]  = 1;
        sel_tab[3]  = 3; dst_tab[3]  = 0;
        sel_tab[7]  = 3; dst_tab[7]  = 1;
        sel_tab[1]  = 1; dst_tab[1]  = 0;
        sel_tab[4]  = 0; dst_tab[4]  = 1;
        sel_tab[2]  = 2; dst_tab[2]  = 0;
        sel_tab[6]  = 2; dst_tab[6]  = 1;
        sel_tab[9]  = 1; dst_tab[9]  = 2;
        sel_tab[11] = 3; dst_tab[11] = 2;
        sel_tab[15] = 3; dst_tab[15] = 3;
        sel_tab[14] = 3; dst_tab[14] = 3;

        // Program 1
        rom[0]  = 8'h35; rom[1]  = 8'h0A; rom[2]  = 8'h01; rom[3]  = 8'hE7;
        rom[4]  = 8'hE9; rom[9]  = 8'h7C; rom[10] = 8'h90; rom[11] = 8'h53;
        rom[12] = 8'h40; rom[13] = 8'h20; rom[14] = 8'hB8; rom[15] = 8'hF0;
        in_port   = 4'h6;
        ack_delay = 0;
        ack_force = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        n_reset   = 1'b0;

        tick();
        chk("rst_rom_req", rom_req, 1'b0);
        chk("rst_halted",  halted,  1'b1);
        chk("rst_sel",     sel,     2'd3);
        chk("rst_imm",     imm,     4'h0);
        chk("rst_pc",      pc,      4'h0);
        chk("rst_n_en",    {n_en_a, n_en_b, n_en_out}, 3'b111);
        chk("rst_illegal", illegal, 1'b0);
        n_reset = 1'b1;

        for (int i = 0; i < 3; i++) tick();
        chk("idle_halted", halted, 1'b1);
        chk("idle_pc",     pc,     4'h0);

        // Free run, ack tied high.
        run = 1'b1;
        tick();
        chk("first_fetch_req", rom_req, 1'b1);
        chk("first_fetch_pc",  pc,      4'h0);
        tick();
        chk("first_exec_sel",  sel,     2'd3);
        chk("first_exec_imm",  imm,     4'h5);
        chk("first_exec_ena",  n_en_a,  1'b0);
        chk("first_exec_enb",  n_en_b,  1'b1);
        tick();
        chk("first_pc_after",  pc,      4'h1);
        chk("first_a_after",   env_a,   4'h5);
        for (int i = 0; i < 40; i++) tick();
        run = 1'b0;
        for (int i = 0; i < 10 && !halted; i++) tick();
        chk("run_stop_halted", halted, 1'b1);
        $display("free run stopped: pc=%0h carry=%0b", pc, carry);

        // Single-step through program 1 from reset.
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        for (int s = 0; s < 12; s++) begin
            step_once(reqs, ills);
            chk("p1_pc",    pc,    p1_pc[s]);
            chk("p1_carry", carry, p1_c[s]);
            chk("p1_a",     env_a, p1_a[s]);
            chk("p1_req",   8'(reqs), 8'd1);
        end
        for (int i = 0; i < 3; i++) tick();
        chk("step_stays_halted", halted, 1'b1);
        chk("step_pc_stable",    pc,     4'h0);

        // Program 2: illegal opcodes, pc wrap, delayed acknowledge.
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hC0; rom[3] = 8'hFF; rom[15] = 8'hA0;
        ack_delay = 3;
        for (int s = 0; s < 5; s++) begin
            step_once(reqs, ills);
            chk("p2_pc",      pc,        p2_pc[s]);
            chk("p2_carry",   carry,     p2_c[s]);
            chk("p2_illegal", 8'(ills),  p2_ill[s]);
            chk("p2_req",     8'(reqs),  8'd4);
        end

        // run drops mid-fetch: the instruction still completes.
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15 && !halted; i++) tick();
        chk("rundrop_halted", halted, 1'b1);
        chk("rundrop_pc",     pc,     4'h1);
        chk("rundrop_a",      env_a,  4'hF);
        $display("run drop: pc=%0h a=%0h", pc, env_a);

        // Reset in the middle of a stalled fetch, then a stray acknowledge.
        ack_delay = 5;
        run = 1'b1;
        tick();
        tick();
        chk("midrst_in_fetch", rom_req, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("midrst_rom_req", rom_req, 1'b0);
        chk("midrst_pc",      pc,      4'h0);
        chk("midrst_halted",  halted,  1'b1);
        chk("midrst_n_en",    {n_en_a, n_en_b, n_en_out}, 3'b111);
        chk("midrst_illegal", illegal, 1'b0);
        run = 1'b0;
        ack_force = 1'b1;
        tick();
        n_reset = 1'b1;
        tick();
        tick();
        chk("lateack_halted",  halted,  1'b1);
        chk("lateack_pc",      pc,      4'h0);
        chk("lateack_rom_req", rom_req, 1'b0);
        chk("lateack_imm",     imm,     4'h0);
        ack_force = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
